// File: rtl/sonar_ranger.sv
// Ultrasonic ranger controller: fires the trigger, times the echo in whole
// centimetres and reports a moving average of the in-range readings.
module sonar_ranger #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TRIG_US   = 10,
  parameter int PERIOD_MS = 60,
  parameter int CM_CLKS   = 2900,
  parameter int DIST_W    = 9,
  parameter int MAX_CM    = 400,
  parameter int AVG_LOG2  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] o_dist,
  output logic              o_valid,
  output logic              o_timeout,
  output logic              o_busy
);
  // 64-bit intermediates: PERIOD_MS*CLK_HZ overflows 32 bits at default settings
  localparam longint TRIG_L = longint'(TRIG_US) * longint'(CLK_HZ) / longint'(1_000_000);
  localparam longint PER_L  = longint'(PERIOD_MS) * longint'(CLK_HZ) / longint'(1000);
  localparam int TRIG_CYC = int'(TRIG_L);
  localparam int PER_CYC  = int'(PER_L);
  localparam int TCW = $clog2(TRIG_CYC + 1);
  localparam int PCW = $clog2(PER_CYC + 1);
  localparam int CCW = $clog2(CM_CLKS + 1);
  localparam int PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NB  = 2 ** PW;
  localparam int SW  = DIST_W + AVG_LOG2;

  localparam logic [TCW-1:0]    TRIG_LAST = TCW'(TRIG_CYC - 1);
  localparam logic [PCW-1:0]    PER_LAST  = PCW'(PER_CYC - 1);
  localparam logic [CCW-1:0]    CM_LAST   = CCW'(CM_CLKS - 1);
  localparam logic [DIST_W-1:0] MAX_V     = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_HOLD} state_t;

  state_t              state_q;
  logic [1:0]          sync_q;
  logic                echo_prev_q;
  logic [TCW-1:0]      tcnt_q;
  logic [PCW-1:0]      per_q;
  logic [PCW-1:0]      wcnt_q;
  logic [CCW-1:0]      ccnt_q;
  logic [DIST_W-1:0]   cm_q;
  logic                trig_q, valid_q, tmo_q, primed_q;
  logic [DIST_W-1:0]   dist_q;
  logic [DIST_W-1:0]   buf_q [NB];
  logic [PW-1:0]       ptr_q;
  logic [SW-1:0]       sum_q, sum_d;
  logic                echo_s, rise, fall;

  assign echo_s = sync_q[1];
  assign rise   = echo_s & ~echo_prev_q;
  assign fall   = ~echo_s & echo_prev_q;
  assign sum_d  = sum_q + SW'(cm_q) - SW'(buf_q[ptr_q]);

  assign trig      = trig_q;
  assign o_dist    = dist_q;
  assign o_valid   = valid_q;
  assign o_timeout = tmo_q;
  assign o_busy    = (state_q != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q      <= '0;
      echo_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], echo};
      echo_prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      primed_q <= 1'b0;
      dist_q   <= '0;
      tcnt_q   <= '0;
      per_q    <= '0;
      wcnt_q   <= '0;
      ccnt_q   <= '0;
      cm_q     <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      for (int i = 0; i < NB; i++) buf_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      // saturating age of the last trigger rise, gates the HOLD exit
      if (per_q != PER_LAST) per_q <= per_q + PCW'(1);
      case (state_q)
        S_IDLE: begin
          if (i_start || i_cont) begin
            state_q <= S_TRIG;
            trig_q  <= 1'b1;
            tcnt_q  <= '0;
            per_q   <= '0;
          end
        end
        S_TRIG: begin
          if (tcnt_q == TRIG_LAST) begin
            trig_q  <= 1'b0;
            state_q <= S_WAIT;
            wcnt_q  <= '0;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        end
        S_WAIT: begin
          if (rise) begin
            state_q <= S_MEAS;
            ccnt_q  <= CCW'(1);   // the rise cycle itself is echo-high time
            cm_q    <= '0;
          end else if (wcnt_q == PER_LAST) begin
            tmo_q   <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            wcnt_q <= wcnt_q + PCW'(1);
          end
        end
        S_MEAS: begin
          if (fall) begin
            valid_q <= 1'b1;
            state_q <= S_HOLD;
            ptr_q   <= (AVG_LOG2 == 0) ? '0 : ptr_q + PW'(1);
            if (!primed_q) begin
              primed_q <= 1'b1;
              for (int i = 0; i < NB; i++) buf_q[i] <= cm_q;
              sum_q  <= SW'(cm_q) << AVG_LOG2;
              dist_q <= cm_q;
            end else begin
              buf_q[ptr_q] <= cm_q;
              sum_q        <= sum_d;
              dist_q       <= DIST_W'(sum_d >> AVG_LOG2);
            end
          end else if (ccnt_q == CM_LAST) begin
            ccnt_q <= '0;
            if (cm_q == MAX_V) begin
              tmo_q   <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              cm_q <= cm_q + DIST_W'(1);
            end
          end else begin
            ccnt_q <= ccnt_q + CCW'(1);
          end
        end
        S_HOLD: begin
          if (per_q == PER_LAST && !echo_s) begin
            if (i_cont) begin
              state_q <= S_TRIG;
              trig_q  <= 1'b1;
              tcnt_q  <= '0;
              per_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger: two instances (no averaging / depth 4)
// share stimulus; a short period keeps every scenario brief.
module tb_sonar_ranger;
  localparam int PER = 2000;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, cont = 1'b0, echo = 1'b0;
  logic trig0, trig2, val0, val2, tmo0, tmo2, busy0, busy2;
  logic [8:0] dist0, dist2;

  always #5 clk = ~clk;

  sonar_ranger #(.CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(2), .CM_CLKS(58),
                 .DIST_W(9), .MAX_CM(400), .AVG_LOG2(0)) u_avg0 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_cont(cont), .echo(echo),
    .trig(trig0), .o_dist(dist0), .o_valid(val0), .o_timeout(tmo0), .o_busy(busy0));

  sonar_ranger #(.CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(2), .CM_CLKS(58),
                 .DIST_W(9), .MAX_CM(400), .AVG_LOG2(2)) u_avg2 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_cont(cont), .echo(echo),
    .trig(trig2), .o_dist(dist2), .o_valid(val2), .o_timeout(tmo2), .o_busy(busy2));

  int cyc = 0, n_cmp = 0, n_bad = 0;
  int rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, fall_cyc = 0, hi_len = 0, last_hi = 0;
  int v2_cnt = 0, t2_cnt = 0, t0_cnt = 0, t2_cyc = 0, both_cnt = 0;
  int q0[$], q2[$];
  logic trig_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig2 && !trig_d) begin
      rise_cnt <= rise_cnt + 1; rise_cyc <= cyc; hi_len <= 1;
    end else if (trig2) hi_len <= hi_len + 1;
    if (!trig2 && trig_d) begin
      fall_cnt <= fall_cnt + 1; fall_cyc <= cyc; last_hi <= hi_len;
    end
    if (val2) begin v2_cnt <= v2_cnt + 1; q2.push_back(int'(dist2)); end
    if (val0) q0.push_back(int'(dist0));
    if (tmo2) begin t2_cnt <= t2_cnt + 1; t2_cyc <= cyc; end
    if (tmo0) t0_cnt <= t0_cnt + 1;
    if ((val2 && tmo2) || (val0 && tmo0)) both_cnt <= both_cnt + 1;
    trig_d <= trig2;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return fall_cnt;
      1: return v2_cnt;
      2: return t2_cnt;
      3: return rise_cnt;
      default: return 0;
    endcase
  endfunction

  task automatic wait_ev(input string tag, input int sel, input int target, input int lim);
    int k = 0;
    while (cnt_of(sel) < target && k < lim) begin tick(1); k++; end
    chk({"wait ", tag}, int'(cnt_of(sel) >= target), 1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    while (busy2 && k < lim) begin tick(1); k++; end
    chk({"idle ", tag}, int'(busy2), 0);
  endtask

  task automatic pulse_echo(input int dly, input int w);
    tick(dly); echo = 1'b1;
    tick(w);   echo = 1'b0;
  endtask

  task automatic go;
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(2);
  endtask

  function automatic int qat(input int which, input int i);
    if (which == 0) return (i >= 0 && i < q0.size()) ? q0[i] : -1;
    return (i >= 0 && i < q2.size()) ? q2[i] : -1;
  endfunction

  int fb, vb, tb0, tb2, rb, n0, n2, ec, q, r[3];
  int avg_exp[4] = '{100, 101, 103, 106};
  int raw_cm[4]  = '{100, 104, 108, 112};

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst trig", int'(trig2), 0);
    chk("rst dist0", int'(dist0), 0);
    chk("rst dist2", int'(dist2), 0);
    chk("rst valid", int'(val2 | val0), 0);
    chk("rst tmo", int'(tmo2 | tmo0), 0);
    chk("rst busy", int'(busy2), 0);
    rst_n = 1'b1; tick(2);

    // single shot, 5800 echo cycles -> 100 cm
    go();
    chk("A busy", int'(busy2), 1);
    wait_ev("A fall", 0, 1, 100);
    chk("A trig len", last_hi, 10);
    pulse_echo(5, 5800);
    wait_ev("A valid", 1, 1, 100);
    wait_idle("A", 3000);
    chk("A nvalid2", v2_cnt, 1);
    chk("A nvalid0", q0.size(), 1);
    chk("A dist0", qat(0, 0), 100);
    chk("A dist2", qat(2, 0), 100);
    chk("A tmo", t2_cnt + t0_cnt, 0);

    // continuous averaging run
    do_reset();
    fb = fall_cnt; vb = v2_cnt; rb = rise_cnt; n0 = q0.size(); n2 = q2.size();
    cont = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ev("B fall", 0, fb + i + 1, 3000);
      if (i == 3) cont = 1'b0;
      pulse_echo(5, raw_cm[i] * 58 + 29);
      wait_ev("B valid", 1, vb + i + 1, 100);
    end
    wait_idle("B", 3000);
    chk("B rises", rise_cnt - rb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("B avg%0d", i), qat(2, n2 + i), avg_exp[i]);
      chk($sformatf("B raw%0d", i), qat(0, n0 + i), raw_cm[i]);
    end

    // no echo at all
    fb = fall_cnt; vb = v2_cnt; tb0 = t0_cnt; tb2 = t2_cnt;
    go();
    wait_ev("C fall", 0, fb + 1, 100);
    wait_ev("C tmo", 2, tb2 + 1, PER + 200);
    chk("C tmo delay", t2_cyc - fall_cyc, PER);
    wait_idle("C", 3000);
    chk("C tmo once2", t2_cnt - tb2, 1);
    chk("C tmo once0", t0_cnt - tb0, 1);
    chk("C no valid", v2_cnt - vb, 0);
    chk("C dist2 kept", int'(dist2), 106);
    chk("C dist0 kept", int'(dist0), 112);

    // echo stuck high past range
    fb = fall_cnt; vb = v2_cnt; tb2 = t2_cnt;
    go();
    wait_ev("D fall", 0, fb + 1, 100);
    tick(5); echo = 1'b1; ec = cyc;
    wait_ev("D tmo", 2, tb2 + 1, 401 * 58 + 200);
    chk("D tmo delay", t2_cyc - ec, 401 * 58 + 2);
    chk("D no valid", v2_cnt - vb, 0);
    chk("D dist2 kept", int'(dist2), 106);
    cont = 1'b1; rb = rise_cnt;
    tick(300);
    chk("D held", rise_cnt - rb, 0);
    chk("D busy", int'(busy2), 1);
    echo = 1'b0; q = cyc;
    wait_ev("D retrig", 3, rb + 1, 50);
    chk("D retrig gap", rise_cyc - q, 3);
    cont = 1'b0;
    wait_ev("D fall2", 0, fb + 2, 100);
    pulse_echo(5, 5 * 58 + 29);
    wait_ev("D valid", 1, vb + 1, 100);
    chk("D dist2", int'(dist2), 82);
    chk("D dist0", int'(dist0), 5);
    wait_idle("D", 3000);

    // reset in TRIG and in MEASURE
    go();
    tick(3);
    #2 rst_n = 1'b0;
    #1 chk("E trig async", int'(trig2), 0);
    chk("E busy async", int'(busy2), 0);
    tick(2); rst_n = 1'b1; tick(2);
    fb = fall_cnt; vb = v2_cnt; tb2 = t2_cnt; n0 = q0.size();
    go();
    wait_ev("E fall", 0, fb + 1, 100);
    tick(5); echo = 1'b1;
    tick(300);
    #2 rst_n = 1'b0;
    #1 chk("E dist2 clr", int'(dist2), 0);
    chk("E dist0 clr", int'(dist0), 0);
    chk("E trig", int'(trig2), 0);
    chk("E busy", int'(busy2), 0);
    tick(3); echo = 1'b0; tick(3); rst_n = 1'b1; tick(2);
    chk("E no strobe", (v2_cnt - vb) + (t2_cnt - tb2) + (q0.size() - n0), 0);
    fb = fall_cnt;
    go();
    wait_ev("E fall2", 0, fb + 1, 100);
    pulse_echo(5, 10 * 58 + 29);
    wait_ev("E valid", 1, vb + 1, 100);
    chk("E dist2", int'(dist2), 10);
    chk("E dist0", int'(dist0), 10);
    wait_idle("E", 3000);

    // continuous spacing, then drop cont
    fb = fall_cnt; vb = v2_cnt; rb = rise_cnt;
    cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ev("F fall", 0, fb + k + 1, 3000);
      r[k] = rise_cyc;
      if (k == 2) cont = 1'b0;
      pulse_echo(5, 5 * 58 + 29);
      wait_ev("F valid", 1, vb + k + 1, 100);
    end
    wait_idle("F", 3000);
    chk("F gap1", r[1] - r[0], PER);
    chk("F gap2", r[2] - r[1], PER);
    chk("F rises", rise_cnt - rb, 3);
    chk("F dist0", int'(dist0), 5);
    chk("no dual strobe", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got cycle %0d, want finish", cyc);
    $fatal(1);
  end
endmodule
